// File: rtl/sga_accumulator.sv
// Segmented-approximate accumulator: sums a handshaked operand stream with carries cut at SEG_W boundaries.
// Optional exact reference accumulator for calibration is enabled by defining SGA_ACC_EXACT_REF_EN.
module sga_accumulator #(
  parameter int DATA_W    = 16,
  parameter int SEG_W     = 4,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = $clog2(MAX_TERMS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_forced
`ifdef SGA_ACC_EXACT_REF_EN
  ,
  output logic [DATA_W+CNT_W-1:0] out_exact
`endif
);

  localparam int               NSEG     = DATA_W / SEG_W;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_TERMS);
  localparam logic             ONE_TERM = (MAX_TERMS == 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Returns {top-segment carry, segmented sum}; lower-segment carries are dropped.
  function automatic logic [DATA_W:0] seg_add(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] sum;
    logic [SEG_W:0]    part;
    logic              carry;
    sum   = {DATA_W{1'b0}};
    part  = {(SEG_W+1){1'b0}};
    carry = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      part = {1'b0, a[k*SEG_W +: SEG_W]} + {1'b0, b[k*SEG_W +: SEG_W]};
      sum[k*SEG_W +: SEG_W] = part[SEG_W-1:0];
      carry = part[SEG_W];
    end
    return {carry, sum};
  endfunction

  state_t            state_r, state_nxt_s;
  logic [DATA_W-1:0] acc_r, acc_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
  logic              ovf_r, ovf_nxt_s;
  logic              beat_s, release_s, done_s, forced_s;
  logic [DATA_W:0]   seg_s;

  logic              in_ready_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_sum_r;
  logic              out_ovf_r;
  logic [CNT_W-1:0]  out_count_r;
  logic              out_forced_r;

  assign beat_s    = in_valid & in_ready_r;
  assign release_s = out_valid_r & out_ready;
  assign seg_s     = seg_add(acc_r, in_data);
  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and accumulator update logic.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    cnt_nxt_s   = cnt_r;
    ovf_nxt_s   = ovf_r;
    done_s      = 1'b0;
    forced_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        acc_nxt_s = {DATA_W{1'b0}};
        cnt_nxt_s = {CNT_W{1'b0}};
        ovf_nxt_s = 1'b0;
        if (beat_s) begin
          acc_nxt_s = in_data;
          cnt_nxt_s = {{(CNT_W-1){1'b0}}, 1'b1};
          if (in_last || ONE_TERM) begin
            state_nxt_s = ST_HOLD;
            done_s      = 1'b1;
            forced_s    = ~in_last;
          end else begin
            state_nxt_s = ST_ACC;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACC: begin
        if (beat_s) begin
          acc_nxt_s = seg_s[DATA_W-1:0];
          cnt_nxt_s = cnt_inc_s;
          ovf_nxt_s = ovf_r | seg_s[DATA_W];
          // in_last wins over the count limit, so a simultaneous end is not "forced".
          if (in_last || (cnt_inc_s == MAX_CNT)) begin
            state_nxt_s = ST_HOLD;
            done_s      = 1'b1;
            forced_s    = ~in_last;
          end else begin
            state_nxt_s = ST_ACC;
          end
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_HOLD: begin
        if (release_s) begin
          state_nxt_s = ST_IDLE;
          acc_nxt_s   = {DATA_W{1'b0}};
          cnt_nxt_s   = {CNT_W{1'b0}};
          ovf_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        acc_nxt_s   = {DATA_W{1'b0}};
        cnt_nxt_s   = {CNT_W{1'b0}};
        ovf_nxt_s   = 1'b0;
      end
    endcase
  end

  // State, accumulator and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      acc_r        <= {DATA_W{1'b0}};
      cnt_r        <= {CNT_W{1'b0}};
      ovf_r        <= 1'b0;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      out_sum_r    <= {DATA_W{1'b0}};
      out_ovf_r    <= 1'b0;
      out_count_r  <= {CNT_W{1'b0}};
      out_forced_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      ovf_r       <= ovf_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_HOLD);
      out_valid_r <= (state_nxt_s == ST_HOLD);
      // Result registers only load on the terminating beat, so they stay stable under backpressure.
      if (done_s) begin
        out_sum_r    <= acc_nxt_s;
        out_ovf_r    <= ovf_nxt_s;
        out_count_r  <= cnt_nxt_s;
        out_forced_r <= forced_s;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_sum    = out_sum_r;
  assign out_ovf    = out_ovf_r;
  assign out_count  = out_count_r;
  assign out_forced = out_forced_r;

`ifdef SGA_ACC_EXACT_REF_EN
  localparam int EXACT_W = DATA_W + CNT_W;

  logic [EXACT_W-1:0] exact_r, exact_nxt_s, exact_in_s;
  logic [EXACT_W-1:0] out_exact_r;

  assign exact_in_s = {{CNT_W{1'b0}}, in_data};

  // Exact reference accumulator, tracking the same beats and clears as acc.
  always_comb begin
    exact_nxt_s = exact_r;
    case (state_r)
      ST_IDLE: begin
        if (beat_s) begin
          exact_nxt_s = exact_in_s;
        end else begin
          exact_nxt_s = {EXACT_W{1'b0}};
        end
      end
      ST_ACC: begin
        if (beat_s) begin
          exact_nxt_s = exact_r + exact_in_s;
        end else begin
          exact_nxt_s = exact_r;
        end
      end
      ST_HOLD: begin
        if (release_s) begin
          exact_nxt_s = {EXACT_W{1'b0}};
        end else begin
          exact_nxt_s = exact_r;
        end
      end
      default: exact_nxt_s = {EXACT_W{1'b0}};
    endcase
  end

  // Exact accumulator and its registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exact_r     <= {EXACT_W{1'b0}};
      out_exact_r <= {EXACT_W{1'b0}};
    end else begin
      exact_r <= exact_nxt_s;
      if (done_s) begin
        out_exact_r <= exact_nxt_s;
      end
    end
  end

  assign out_exact = out_exact_r;
`endif

endmodule

// File: doc/sga_accumulator.md
Name: sga_accumulator

Overview:
- Sequential accumulation stage downstream of the 16-bit segmented approximate adder in the CNN datapath.
- Sums a handshaked stream of DATA_W-bit partial products using segmented addition: carries are cut at every SEG_W boundary.
- Emits one approximate sum per stream, with a sticky top-segment overflow flag and a term count.
- Feeds the activation/requantise stage.

Parameters:
- DATA_W, 16: operand and accumulator width; must be a multiple of SEG_W.
- SEG_W, 4: segment width; no carry propagates between segments.
- MAX_TERMS, 256: maximum beats per stream; the stream is force-terminated when this is reached.
- CNT_W, $clog2(MAX_TERMS)+1: term counter width (derived).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  stage can accept a beat
- in_data  input  DATA_W  operand to accumulate
- in_last  input  1  final beat of current stream
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  DATA_W  segmented-approximate sum
- out_ovf  output  1  sticky carry-out of top segment seen during stream
- out_count  output  CNT_W  number of beats accumulated
- out_forced  output  1  stream ended by MAX_TERMS, not in_last

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge.
- Reset values: state=IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_ovf=0, out_count=0, out_forced=0, in_ready=0 during reset cycle, 1 in the first cycle after reset.
- Segmented add S = A (+) B:
  - For segment k, S[k*SEG_W +: SEG_W] = (A_k + B_k) mod 2^SEG_W.
  - Carry-in of every segment is 0.
  - Carry-out of the top segment is the overflow bit; other segment carries are discarded.
- FSM states:
  - IDLE: in_ready=1, acc=0. A beat (in_valid & in_ready) sets acc=in_data, cnt=1, ovf=0, and goes to ACC. If that beat has in_last=1, or MAX_TERMS=1, go straight to HOLD instead.
  - ACC: in_ready=1. A beat sets acc = acc (+) in_data, cnt=cnt+1, ovf |= top carry. Go to HOLD if in_last=1 or the new cnt==MAX_TERMS. Otherwise stay in ACC. No beat means state is held.
  - HOLD: in_ready=0, out_valid=1.
- HOLD outputs and exit:
  - out_sum, out_ovf, out_count are registered from the values updated on the terminating beat.
  - out_forced=1 iff termination came from cnt==MAX_TERMS with in_last=0.
  - Outputs are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready go to IDLE. out_valid drops next cycle; acc/cnt/ovf clear.
  - No new beat is accepted in the handshake cycle, so the minimum gap between streams is 1 cycle.
- Latency: the result is valid the cycle after the terminating beat is accepted.
- Throughput: 1 beat/cycle within a stream.
- in_last with cnt==MAX_TERMS on the same beat: terminate with out_forced=0.
- in_valid while in HOLD: ignored, not consumed; upstream holds its data.
- rst_n low mid-stream or in HOLD: everything returns to reset values next edge; the partial stream is discarded and out_valid drops.
- in_data and in_last are don't-care when in_valid=0.

Optional Feature:
- Macro SGA_ACC_EXACT_REF_EN.
- Defined:
  - Adds output port out_exact, width DATA_W+CNT_W.
  - A parallel exact accumulator is updated on the same beats as acc and cleared on the same events.
  - out_exact is registered and presented with out_sum under the same handshake, so out_exact minus out_sum gives the approximation error for calibration.
- Not defined:
  - Port and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then stream {0x1234, 0x1111(last)} -> out_sum=0x2345, out_ovf=0, out_count=2, out_forced=0; out_valid 1 cycle after last beat.
- Stream {0x000F, 0x0001(last)} -> out_sum=0x0000, since the segment-0 carry is dropped. With SGA_ACC_EXACT_REF_EN, out_exact=0x0010.
- Stream {0xF000, 0x1000(last)} -> out_sum=0x0000, out_ovf=1. Next stream {0x0001(last)} -> out_ovf=0, out_count=1, confirming clear between streams.
- out_ready held 0 for 5 cycles in HOLD with in_valid=1 -> out_* stable and in_ready=0 throughout. Assert out_ready -> IDLE next cycle and the held beat is accepted one cycle later.
- MAX_TERMS=4, feed 4 beats of 0x0001 with in_last=0 -> out_sum=0x0004, out_count=4, out_forced=1. 5th beat becomes the first of the next stream.
- rst_n low for 1 cycle after 2 beats of a stream -> out_valid=0, in_ready=1 after release. Stream {0x0002(last)} -> out_sum=0x0002, out_count=1.
